// File: rtl/zreg_arbiter.sv
// Round-robin two-port access controller for a 4 x 8-bit zregister file.
// Serialises A/B requests through IDLE -> ACCESS -> RELEASE with registered outputs.
module zreg_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [SEL_W-1:0]  a_sel_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_gnt_o,
    output logic              a_done_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [SEL_W-1:0]  b_sel_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_gnt_o,
    output logic              b_done_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic [DATA_W-1:0] rf_in_o,
    output logic              rf_opcode_o,
    output logic [SEL_W-1:0]  rf_sel_o,
    input  logic [DATA_W-1:0] rf_out_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  in_q, in_d;
    logic               op_q, op_d;
    logic               a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic               a_done_q, a_done_d, b_done_q, b_done_d;
    logic [DATA_W-1:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic               busy_q, busy_d;
    logic               win;

    // State and output registers; reset leaves the pointer at B so A wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= PORT_A;
            last_q    <= PORT_B;
            we_q      <= 1'b0;
            sel_q     <= '0;
            in_q      <= '0;
            op_q      <= 1'b0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            in_q      <= in_d;
            op_q      <= op_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

    // Next state plus the values every registered output takes in that state.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        sel_d     = sel_q;
        in_d      = in_q;
        op_d      = 1'b0;
        a_gnt_d   = 1'b0;
        b_gnt_d   = 1'b0;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        win       = PORT_A;

        case (state_q)
            S_IDLE: begin
                if (a_req_i || b_req_i) begin
                    win     = (a_req_i && b_req_i) ? ~last_q : b_req_i;
                    owner_d = win;
                    last_d  = win;
                    we_d    = win ? b_we_i    : a_we_i;
                    sel_d   = win ? b_sel_i   : a_sel_i;
                    in_d    = win ? b_wdata_i : a_wdata_i;
                    op_d    = we_d;
                    a_gnt_d = ~win;
                    b_gnt_d = win;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Strobe drops here while select/data hold through RELEASE.
                a_done_d = ~owner_q;
                b_done_d = owner_q;
                if (!we_q) begin
                    if (owner_q) b_rdata_d = rf_out_i;
                    else         a_rdata_d = rf_out_i;
                end
                state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign a_gnt_o     = a_gnt_q;
    assign b_gnt_o     = b_gnt_q;
    assign a_done_o    = a_done_q;
    assign b_done_o    = b_done_q;
    assign a_rdata_o   = a_rdata_q;
    assign b_rdata_o   = b_rdata_q;
    assign rf_in_o     = in_q;
    assign rf_sel_o    = sel_q;
    assign rf_opcode_o = op_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_zreg_arbiter.sv
// Directed bench for zreg_arbiter with a behavioural zregister file and per-port scoreboards.
module tb_zreg_arbiter;

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [1:0] a_sel = '0, b_sel = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_gnt_o, a_done_o, b_gnt_o, b_done_o;
    logic [7:0] a_rdata_o, b_rdata_o;
    logic [7:0] rf_in_o, rf_out;
    logic       rf_opcode_o, busy_o;
    logic [1:0] rf_sel_o;

    logic [7:0] zregs [4];
    logic [7:0] shadow [4];
    exp_t       qa [$];
    exp_t       qb [$];
    logic [7:0] a_rd_m = '0, b_rd_m = '0;
    logic       prev_op = 1'b0;
    logic [1:0] prev_sel = '0;
    logic       sustain = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // External zregister: write on rising edge when OPCODE=1, asynchronous read.
    always @(posedge clk) if (rf_opcode_o) zregs[rf_sel_o] <= rf_in_o;
    assign rf_out = zregs[rf_sel_o];

    zreg_arbiter #(.DATA_W(8), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_sel_i(a_sel), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt_o), .a_done_o(a_done_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req), .b_we_i(b_we), .b_sel_i(b_sel), .b_wdata_i(b_wdata),
        .b_gnt_o(b_gnt_o), .b_done_o(b_done_o), .b_rdata_o(b_rdata_o),
        .rf_in_o(rf_in_o), .rf_opcode_o(rf_opcode_o), .rf_sel_o(rf_sel_o),
        .rf_out_i(rf_out), .busy_o(busy_o)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge and run the continuous checks.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (prev_op) begin
            check(32'(rf_sel_o), 32'(prev_sel), "sel_hold_after_strobe");
            check(32'(rf_opcode_o), 32'd0, "strobe_single_cycle");
        end
        if (!busy_o) check(32'(rf_opcode_o), 32'd0, "opcode_idle");
        if (a_gnt_o && !sustain) a_req = 1'b0;
        if (b_gnt_o && !sustain) b_req = 1'b0;
        if (a_done_o) begin
            check(32'(qa.size() != 0), 32'd1, "a_done_expected");
            if (qa.size() != 0) begin
                e = qa.pop_front();
                if (e.rd) a_rd_m = e.data;
                check(32'(a_rdata_o), 32'(a_rd_m), "a_rdata");
                check(32'(b_rdata_o), 32'(b_rd_m), "b_rdata_untouched");
            end
        end
        if (b_done_o) begin
            check(32'(qb.size() != 0), 32'd1, "b_done_expected");
            if (qb.size() != 0) begin
                e = qb.pop_front();
                if (e.rd) b_rd_m = e.data;
                check(32'(b_rdata_o), 32'(b_rd_m), "b_rdata");
                check(32'(a_rdata_o), 32'(a_rd_m), "a_rdata_untouched");
            end
        end
        prev_op  = rf_opcode_o;
        prev_sel = rf_sel_o;
    endtask

    task automatic req_a(input logic we, input logic [1:0] sel, input logic [7:0] d);
        exp_t e;
        a_req = 1'b1; a_we = we; a_sel = sel; a_wdata = d;
        e.rd = ~we;
        if (we) shadow[sel] = d;
        e.data = shadow[sel];
        qa.push_back(e);
    endtask

    task automatic req_b(input logic we, input logic [1:0] sel, input logic [7:0] d);
        exp_t e;
        b_req = 1'b1; b_we = we; b_sel = sel; b_wdata = d;
        e.rd = ~we;
        if (we) shadow[sel] = d;
        e.data = shadow[sel];
        qb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        qa.delete(); qb.delete();
        a_rd_m = '0; b_rd_m = '0;
        prev_op = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((a_req || b_req || busy_o || qa.size() != 0 || qb.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check(32'(n < 100), 32'd1, {tag, "_timeout"});
    endtask

    initial begin
        // Reset state
        do_reset();
        check(32'(busy_o), 32'd0, "rst_busy");
        check(32'(rf_opcode_o), 32'd0, "rst_opcode");
        check(32'(rf_sel_o), 32'd0, "rst_sel");
        check(32'(rf_in_o), 32'd0, "rst_in");
        check(32'({a_gnt_o, b_gnt_o, a_done_o, b_done_o}), 32'd0, "rst_pulses");
        check(32'({a_rdata_o, b_rdata_o}), 32'd0, "rst_rdata");

        // A write R2=F0 with exact timing, then A read back
        req_a(1'b1, 2'd2, 8'hF0);
        tick();
        check(32'(a_gnt_o), 32'd1, "t1_gnt");
        check(32'(rf_opcode_o), 32'd1, "t1_opcode");
        check(32'(rf_sel_o), 32'd2, "t1_sel");
        check(32'(rf_in_o), 32'hF0, "t1_in");
        check(32'(busy_o), 32'd1, "t1_busy");
        tick();
        check(32'(a_gnt_o), 32'd0, "t1_gnt_pulse");
        check(32'(a_done_o), 32'd1, "t1_done");
        check(32'(rf_opcode_o), 32'd0, "t1_opcode_release");
        check(32'(rf_sel_o), 32'd2, "t1_sel_release");
        tick();
        check(32'(busy_o), 32'd0, "t1_idle");
        req_a(1'b0, 2'd2, 8'h00);
        wait_idle("t1_read");
        check(32'(a_rdata_o), 32'hF0, "t1_rdata");

        // Simultaneous writes after reset: A first, B three cycles later
        do_reset();
        req_a(1'b1, 2'd0, 8'hAA);
        req_b(1'b1, 2'd1, 8'hCC);
        tick();
        check(32'({a_gnt_o, b_gnt_o}), 32'b10, "t2_a_first");
        tick();
        tick();
        check(32'(b_gnt_o), 32'd0, "t2_b_waits");
        tick();
        check(32'(b_gnt_o), 32'd1, "t2_b_gnt");
        wait_idle("t2_write");
        req_a(1'b0, 2'd0, 8'h00);
        req_b(1'b0, 2'd1, 8'h00);
        wait_idle("t2_read");
        check(32'(a_rdata_o), 32'hAA, "t2_r0");
        check(32'(b_rdata_o), 32'hCC, "t2_r1");

        // Sustained contention for 12 cycles: A,B,A,B grants every third cycle
        do_reset();
        sustain = 1'b1;
        req_a(1'b0, 2'd0, 8'h00);
        req_a(1'b0, 2'd0, 8'h00);
        req_b(1'b0, 2'd1, 8'h00);
        req_b(1'b0, 2'd1, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check(32'(a_gnt_o), 32'(k == 1 || k == 7), "t3_a_gnt");
            check(32'(b_gnt_o), 32'(k == 4 || k == 10), "t3_b_gnt");
            check(32'(busy_o), 32'(k % 3 != 0), "t3_busy");
        end
        a_req = 1'b0;
        b_req = 1'b0;
        sustain = 1'b0;
        wait_idle("t3");

        // B writes R3, A read of R3 queued behind it
        req_b(1'b1, 2'd3, 8'h0F);
        tick();
        check(32'(b_gnt_o), 32'd1, "t4_b_gnt");
        req_a(1'b0, 2'd3, 8'h00);
        wait_idle("t4");
        check(32'(a_rdata_o), 32'h0F, "t4_a_rdata");
        check(32'(b_rdata_o), 32'hCC, "t4_b_rdata_kept");

        // Reset mid-ACCESS of an A write to R2
        req_a(1'b1, 2'd2, 8'h5A);
        tick();
        check(32'(a_gnt_o), 32'd1, "t5_gnt");
        check(32'(rf_opcode_o), 32'd1, "t5_opcode_access");
        rst_n = 1'b0;
        prev_op = 1'b0;
        #1;
        check(32'(rf_opcode_o), 32'd0, "t5_opcode_abort");
        check(32'(busy_o), 32'd0, "t5_busy_abort");
        do_reset();
        check(32'(a_done_o), 32'd0, "t5_no_done");
        req_a(1'b0, 2'd0, 8'h00);
        req_b(1'b0, 2'd1, 8'h00);
        tick();
        check(32'({a_gnt_o, b_gnt_o}), 32'b10, "t5_a_first");
        wait_idle("t5");
        check(32'(a_rdata_o), 32'hAA, "t5_r0");
        check(32'(b_rdata_o), 32'hCC, "t5_r1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zreg_arbiter.md
Name: zreg_arbiter

Overview:
- Two-requester access controller for the 4 x 8-bit zregister file (single port: IN, OPCODE 1=write/0=read, REG_SEL, OUT).
- Serialises requests from port A (execute unit) and port B (debug/load unit) with round-robin arbitration.
- Sequences OPCODE so a write strobe never overlaps a REG_SEL change.
- Captures read data and returns it with a one-cycle DONE pulse.

Parameters:
DATA_W, 8, register data width (matches zregister IN/OUT)
SEL_W, 2, register select width (matches zregister REG_SEL)

Ports:
CLK  input  1  single clock; all state changes on rising edge
RST_N  input  1  reset, asynchronous assert, active-low
A_REQ  input  1  port A request; held until A_GNT seen
A_WE  input  1  port A op: 1=write, 0=read; stable while A_REQ=1
A_SEL  input  SEL_W  port A register index
A_WDATA  input  DATA_W  port A write data
A_GNT  output  1  one-cycle pulse: A request accepted
A_DONE  output  1  one-cycle pulse: A op complete
A_RDATA  output  DATA_W  read result for A; valid when A_DONE=1 after a read, held until next A read completes
B_REQ, B_WE, B_SEL, B_WDATA, B_GNT, B_DONE, B_RDATA  same as A, for port B
RF_IN  output  DATA_W  to zregister IN
RF_OPCODE  output  1  to zregister OPCODE
RF_SEL  output  SEL_W  to zregister REG_SEL
RF_OUT  input  DATA_W  from zregister OUT
BUSY  output  1  1 whenever state != IDLE

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State=IDLE.
  - All outputs 0: RF_OPCODE, RF_SEL, RF_IN, GNTs, DONEs, RDATAs, BUSY.
  - Round-robin pointer LAST=B, so A wins the first contention.
- States: IDLE -> ACCESS -> RELEASE -> IDLE. Every transition takes exactly one cycle; IDLE holds while no REQ.
- IDLE:
  - REQ sampled only here.
  - One REQ high: that port wins.
  - Both high: the port != LAST wins.
  - On the edge: latch winner's WE/SEL/WDATA and owner; LAST<=winner; go to ACCESS.
- ACCESS:
  - Winner's GNT=1 for this cycle only.
  - RF_SEL=latched SEL, RF_IN=latched WDATA, RF_OPCODE=latched WE.
  - Read: RF_OPCODE=0; RF_OUT sampled at the end of ACCESS into the owner's RDATA.
  - Requester may drop REQ after seeing GNT.
- RELEASE:
  - RF_OPCODE=0; RF_SEL and RF_IN hold the latched values, so the strobe falls before the select moves.
  - Owner's DONE=1 for this cycle; RDATA is valid if the op was a read.
  - Next state IDLE.
- Latency and throughput:
  - REQ sampled in IDLE at edge t: GNT in cycle t+1, DONE in cycle t+2.
  - Maximum one op per 3 cycles.
- REQ still high in IDLE after DONE is treated as a new request; back-to-back from one port is allowed when the other port is idle.
- A write with WE=1 holds RF_OPCODE=1 for exactly one cycle.
- Outputs are registered; no combinational path from A/B inputs to RF_* or GNT.
- RF_OPCODE is always 0 in IDLE.
- RDATA of the non-owner port is never modified.
- Reset mid-ACCESS or mid-RELEASE:
  - Op aborted, RF_OPCODE drops immediately.
  - No DONE issued; pointer returns to LAST=B.
  - A write aborted mid-ACCESS may or may not have landed; requesters must reissue.
- REQ changing while not in IDLE: ignored; only the latched copy is used.

Test Plan:
1. A write then read: A_REQ,A_WE=1,A_SEL=2,A_WDATA=8'hF0 -> A_GNT 1 cycle later, RF_OPCODE=1 for exactly 1 cycle with RF_SEL=2, A_DONE next cycle. Then A read SEL=2 -> A_RDATA=8'hF0 with A_DONE.
2. Simultaneous requests after reset: A write R0=8'hAA and B write R1=8'hCC raised together -> A granted first, B granted 3 cycles later. Reads return R0=8'hAA, R1=8'hCC.
3. Sustained contention: both REQ held high for 12 cycles (reads of R0/R1) -> GNT alternates A,B,A,B. One GNT every 3 cycles; BUSY low only in IDLE cycles.
4. Cross-port read-after-write: B writes R3=8'h0F, A read of R3 queued behind it -> A_RDATA=8'h0F. B_RDATA unchanged from its prior value.
5. Reset mid-op: RST_N=0 asserted mid-ACCESS of an A write to R2 -> same-time RF_OPCODE=0, BUSY=0, no A_DONE. After release, first contention grants A.
6. Write strobe hygiene: monitor RF_SEL and RF_OPCODE across the scenarios above -> RF_SEL never changes while RF_OPCODE=1. RF_OPCODE is never 1 in two consecutive cycles.
